sigma_delta_decimator: RTL and testbench
========================================

# sigma_delta_decimator

Receive-side counterpart of the first-order sigma-delta modulator. Takes a 1-bit pulse-density stream and recovers N-bit unsigned PCM samples with a third-order CIC (sinc³) decimation filter, decimation ratio R = 2^LOG2_R. Sits between a modulator-encoded bitstream (loopback or external source) and PCM consumers. Output rate is one sample per R accepted input bits.

## Interface
- N, 16: output sample width; also the modulator's input width, so a density of X/2^N decodes to X.
- LOG2_R, 6: log2 of the decimation ratio; requires LOG2_R ≥ 1 and 3·LOG2_R ≥ N, otherwise `$error` at elaboration.
- clk  input  1  clock
- n_reset  input  1  reset, synchronous, active-low
- in  input  1  bitstream sample
- in_valid  input  1  qualifies `in`; `in` is ignored when low
- out  output  N  decoded PCM sample, unsigned
- out_valid  output  1  one-cycle strobe marking a new `out`

## Operation
- Internal width W = 3·LOG2_R + 1. All integrator and comb arithmetic is modulo 2^W; wrap is intentional and correct.
- Integrators update only on cycles with in_valid=1, and all three use pre-update values:
  - i1 ← i1 + in (zero-extended)
  - i2 ← i2 + i1
  - i3 ← i3 + i2
- Sample counter `cnt` (LOG2_R bits) increments on in_valid and wraps R-1 → 0.
- Tick = in_valid && cnt == R-1. On a tick, using the registered i3 before its update:
  - d1 = i3 − z1, d2 = d1 − z2, d3 = d2 − z3
  - z1 ← i3, z2 ← d1, z3 ← d2
- Scaling: raw = d3, with true range 0…R³. Let SH = 3·LOG2_R − N.
  - out ← raw >> SH, saturated to 2^N − 1.
  - Saturation is reachable only for an all-ones input.
- Warm-up: a 2-bit counter suppresses out_valid for the first 3 ticks after reset. `out` still updates on those ticks. The counter saturates at 3.
- When in_valid=0, all state holds and no tick occurs.

## Timing
- Reset (n_reset=0 at a clk edge): i1–i3, z1–z3, cnt, warm-up counter, `out` and out_valid all become 0. The same applies to a reset asserted mid-operation; no partial sample is emitted afterwards.
- out and out_valid are registered and change exactly 1 cycle after the tick cycle.
- out_valid is high for exactly one cycle per tick from the 4th tick onward. Between strobes `out` holds its value.
- Continuous in_valid gives a strobe every R cycles. Gaps in in_valid stretch the spacing by the number of invalid cycles.
- Reset and tick in the same cycle: reset wins, and no strobe follows.
- Filter group delay from input bit to its effect on `out`: 3 integrator cycles plus the comb, with no additional pipeline stages.

## Structure
- Shared package `sigma_delta_pkg`:
  - function `cic_width(log2_r)` returning 3·log2_r + 1
  - constant CIC_ORDER = 3
  - constant WARMUP_TICKS = 3
- The modulator and any future variants import the same package.
- One natural sub-module, `cic_integrator` (W-bit accumulator with enable), instantiated three times. Combs, counter and scaling stay inline.

## Test plan
- Reset: hold n_reset low 2 cycles with random `in` and in_valid=1 → out=0, out_valid=0. After release, the first strobe appears exactly 4·64+1 = 257 cycles later (N=16, LOG2_R=6).
- Constant zeros: in=0 continuously → every out_valid shows out=0x0000.
- Constant ones: in=1 continuously → every out_valid shows out=0xFFFF (raw 2^18 saturates).
- Alternating 1010… → out=0x8000 on every strobe.
- Loopback: sigma_delta (N=16) driven with 0x4000 feeds this block with in_valid=1 → every strobe shows exactly 0x4000. Repeat with 0xC000 → 0xC000.
- Gated input and mid-operation reset:
  - Random in_valid at 50% duty → strobe spacing equals 64 accepted bits.
  - Assert n_reset mid-frame → no strobe until 4 full frames after release.

Source files
------------

// File: rtl/sigma_delta_pkg.sv
// sigma_delta_pkg: constants and helpers shared by the sigma-delta modulator,
// the CIC decimator and any later variants.
// No ports; import with `import sigma_delta_pkg::*;`.

package sigma_delta_pkg;

  // Number of integrator/comb stages in the sinc^3 decimator.
  localparam int CIC_ORDER = 3;

  // Ticks whose output is discarded while the comb delay line fills.
  localparam int WARMUP_TICKS = 3;

  // Register width needed to hold the CIC gain R^3 = 2^(3*log2_r) without
  // ambiguity; one extra bit over the gain so raw == R^3 is representable.
  function automatic int cic_width(input int log2_r);
    return CIC_ORDER * log2_r + 1;
  endfunction

endpackage

// File: rtl/cic_integrator.sv
// cic_integrator: W-bit wrapping accumulator with enable, one CIC integrator stage.
// Latency: acc reflects an addend one clock after the enabled edge.
// Ports: clk, n_reset (sync, active-low), en, add[W-1:0] in; acc[W-1:0] out.

module cic_integrator #(
  parameter int W = 19
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         en,
  input  logic [W-1:0] add,
  output logic [W-1:0] acc
);

  // Overflow wraps modulo 2^W; the comb section differences cancel it.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + add;
    end
  end

endmodule

// File: rtl/sigma_delta_decimator.sv
// sigma_delta_decimator: 1-bit pulse-density stream -> N-bit unsigned PCM via
// a sinc^3 CIC filter decimating by R = 2^LOG2_R. One sample per R accepted bits.
// Ports: clk, n_reset (sync, active-low), in, in_valid in; out[N-1:0], out_valid out.
// No backpressure: in_valid=0 freezes every state element, out_valid is a one-cycle strobe.

module sigma_delta_decimator
  import sigma_delta_pkg::*;
#(
  parameter int N      = 16,
  parameter int LOG2_R = 6
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         in,
  input  logic         in_valid,
  output logic [N-1:0] out,
  output logic         out_valid
);

  localparam int W  = cic_width(LOG2_R);
  // Full-scale raw value is R^3 = 2^(3*LOG2_R); shifting by SH maps it to 2^N.
  localparam int SH = CIC_ORDER * LOG2_R - N;

  if (LOG2_R < 1 || CIC_ORDER * LOG2_R < N) begin : g_param_check
    $error("sigma_delta_decimator: need LOG2_R >= 1 and 3*LOG2_R >= N");
  end

  // ---------------------------------------------------------------------------
  // Integrators: each stage adds the previous stage's registered (pre-update)
  // value, so the three form a pure register chain with no combinational ripple.
  // ---------------------------------------------------------------------------
  logic [W-1:0] i1, i2, i3;
  logic [W-1:0] in_ext;

  assign in_ext = {{(W-1){1'b0}}, in};

  cic_integrator #(.W(W)) u_int1 (
    .clk     (clk),
    .n_reset (n_reset),
    .en      (in_valid),
    .add     (in_ext),
    .acc     (i1)
  );

  cic_integrator #(.W(W)) u_int2 (
    .clk     (clk),
    .n_reset (n_reset),
    .en      (in_valid),
    .add     (i1),
    .acc     (i2)
  );

  cic_integrator #(.W(W)) u_int3 (
    .clk     (clk),
    .n_reset (n_reset),
    .en      (in_valid),
    .add     (i2),
    .acc     (i3)
  );

  // ---------------------------------------------------------------------------
  // Decimation counter: tick on the accepted bit that completes a frame.
  // ---------------------------------------------------------------------------
  logic [LOG2_R-1:0] cnt;
  logic              tick;

  assign tick = in_valid && (&cnt);

  // ---------------------------------------------------------------------------
  // Comb section, evaluated combinationally at the decimated rate from the
  // registered i3; delay registers only load on a tick.
  // ---------------------------------------------------------------------------
  logic [W-1:0] z1, z2, z3;
  logic [W-1:0] d1, d2, d3;
  logic [W-1:0] scaled;
  logic [N-1:0] sat_out;

  always_comb begin
    d1 = i3 - z1;
    d2 = d1 - z2;
    d3 = d2 - z3;
    // d3 lies in 0..R^3; after the shift only R^3 itself (all-ones input)
    // exceeds N bits, and it clamps to full scale.
    scaled = d3 >> SH;
    if (|scaled[W-1:N]) begin
      sat_out = '1;
    end else begin
      sat_out = scaled[N-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Warm-up: the first ticks see a partially filled comb history, so their
  // samples are written to `out` but not announced.
  // ---------------------------------------------------------------------------
  logic [1:0] warm_cnt;
  logic       warm_done;

  assign warm_done = (warm_cnt == 2'(WARMUP_TICKS));

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      cnt       <= '0;
      z1        <= '0;
      z2        <= '0;
      z3        <= '0;
      warm_cnt  <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        cnt <= cnt + 1'b1;
      end
      if (tick) begin
        z1  <= i3;
        z2  <= d1;
        z3  <= d2;
        out <= sat_out;
        if (warm_done) begin
          out_valid <= 1'b1;
        end else begin
          warm_cnt <= warm_cnt + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sigma_delta_decimator.sv
// tb_sigma_delta_decimator: directed checks of the sinc^3 decimator (N=16, R=64).
// Expected outputs are hand-derived densities and frame timings.
// Drives inputs and samples outputs 1 time unit after each rising clk edge.

module tb_sigma_delta_decimator;

  logic        clk;
  logic        n_reset;
  logic        in_bit;
  logic        in_valid;
  logic [15:0] out;
  logic        out_valid;

  int vectors;
  int miscompares;

  logic [15:0] mod_acc;

  sigma_delta_decimator #(.N(16), .LOG2_R(6)) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .in        (in_bit),
    .in_valid  (in_valid),
    .out       (out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // First-order sigma-delta modulator: carry out of an N-bit phase accumulator.
  task automatic mod_bit(input logic [15:0] x, output logic b);
    logic [16:0] s;
    s       = {1'b0, mod_acc} + {1'b0, x};
    b       = s[16];
    mod_acc = s[15:0];
  endtask

  // mode 0: constant x[0]; mode 1: alternating 1010...; mode 2: modulator of x
  task automatic gen_bit(input int mode, input logic [15:0] x, input int idx,
                         output logic b);
    case (mode)
      0:       b = x[0];
      1:       b = (idx % 2 == 0);
      default: mod_bit(x, b);
    endcase
  endtask

  task automatic do_reset(input int cycles);
    n_reset  = 1'b0;
    in_valid = 1'b1;
    repeat (cycles) begin
      in_bit = 1'($urandom_range(0, 1));
      step();
    end
    n_reset = 1'b1;
    mod_acc = '0;
  endtask

  task automatic test_reset();
    int first;
    first    = -1;
    n_reset  = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_bit = 1'($urandom_range(0, 1));
      step();
      vectors++;
      if (out !== 16'h0000 || out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_state cyc%0d: out=%h out_valid=%b, want 0000/0",
                 i, out, out_valid);
      end
    end
    n_reset = 1'b1;
    // Count edges from the last reset edge (=1); first strobe lands on 257.
    for (int c = 0; c < 300; c++) begin
      in_bit   = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      step();
      if (out_valid && first < 0) first = c + 2;
    end
    vectors++;
    if (first !== 257) begin
      miscompares++;
      $display("FAIL reset_first_strobe: got edge %0d, want 257", first);
    end
  endtask

  // Six frames of continuous input: strobes after frames 4, 5, 6.
  task automatic test_pattern(input int mode, input logic [15:0] x,
                              input logic [15:0] exp, input string name);
    int          strobes;
    logic        b;
    logic [15:0] held;
    do_reset(2);
    strobes = 0;
    held    = '0;
    for (int c = 0; c < 6 * 64; c++) begin
      gen_bit(mode, x, c, b);
      in_bit   = b;
      in_valid = 1'b1;
      step();
      if (out_valid) begin
        vectors++;
        if (out !== exp) begin
          miscompares++;
          $display("FAIL %s value strobe%0d: out=%h, want %h", name, strobes, out, exp);
        end
        if (c !== 255 + 64 * strobes) begin
          vectors++;
          miscompares++;
          $display("FAIL %s timing strobe%0d: cycle %0d, want %0d",
                   name, strobes, c, 255 + 64 * strobes);
        end
        strobes++;
        held = out;
      end else if (strobes > 0) begin
        vectors++;
        if (out !== held) begin
          miscompares++;
          $display("FAIL %s hold cyc%0d: out=%h, want %h", name, c, out, held);
        end
      end
    end
    vectors++;
    if (strobes !== 3) begin
      miscompares++;
      $display("FAIL %s strobe_count: got %0d, want 3", name, strobes);
    end
  endtask

  // 50% random in_valid with a 0x4000 modulator advanced only on accepted bits.
  task automatic test_gated();
    int   accepted;
    int   strobes;
    int   exp_strobes;
    logic b;
    logic v;
    do_reset(2);
    accepted = 0;
    strobes  = 0;
    for (int c = 0; c < 1200; c++) begin
      v = 1'($urandom_range(0, 1));
      if (v) begin
        mod_bit(16'h4000, b);
        in_bit = b;
      end else begin
        in_bit = 1'($urandom_range(0, 1));
      end
      in_valid = v;
      step();
      if (v) accepted++;
      if (out_valid) begin
        vectors++;
        if (!v || accepted !== 256 + 64 * strobes || out !== 16'h4000) begin
          miscompares++;
          $display("FAIL gated strobe%0d: accepted=%0d valid=%b out=%h, want %0d/1/4000",
                   strobes, accepted, v, out, 256 + 64 * strobes);
        end
        strobes++;
      end
    end
    in_valid    = 1'b0;
    exp_strobes = (accepted >= 256) ? (accepted - 256) / 64 + 1 : 0;
    vectors++;
    if (strobes !== exp_strobes) begin
      miscompares++;
      $display("FAIL gated strobe_count: got %0d, want %0d", strobes, exp_strobes);
    end
  endtask

  // Reset mid-frame after strobes have started; warm-up must restart fully.
  task automatic test_midreset();
    int   first;
    logic b;
    do_reset(2);
    for (int c = 0; c < 5 * 64 + 20; c++) begin
      gen_bit(1, 16'h0, c, b);
      in_bit   = b;
      in_valid = 1'b1;
      step();
    end
    n_reset = 1'b0;
    step();
    vectors++;
    if (out !== 16'h0000 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_state: out=%h out_valid=%b, want 0000/0", out, out_valid);
    end
    n_reset = 1'b1;
    first   = -1;
    for (int c = 0; c < 300; c++) begin
      gen_bit(1, 16'h0, c, b);
      in_bit = b;
      step();
      if (out_valid && first < 0) begin
        first = c;
        vectors++;
        if (out !== 16'h8000) begin
          miscompares++;
          $display("FAIL midreset_value: out=%h, want 8000", out);
        end
      end
    end
    vectors++;
    if (first !== 255) begin
      miscompares++;
      $display("FAIL midreset_first_strobe: cycle %0d, want 255", first);
    end
  endtask

  // Reset asserted on the edge that would complete the 5th frame's tick.
  task automatic test_reset_tick_collision();
    logic b;
    int   strobes;
    do_reset(2);
    strobes = 0;
    for (int c = 0; c < 5 * 64 - 1; c++) begin
      gen_bit(0, 16'h1, c, b);
      in_bit   = b;
      in_valid = 1'b1;
      step();
      if (out_valid) strobes++;
    end
    vectors++;
    if (strobes !== 1) begin
      miscompares++;
      $display("FAIL collision_pre_strobes: got %0d, want 1", strobes);
    end
    n_reset = 1'b0;
    step();
    vectors++;
    if (out_valid !== 1'b0 || out !== 16'h0000) begin
      miscompares++;
      $display("FAIL collision_reset_wins: out=%h out_valid=%b, want 0000/0", out, out_valid);
    end
    n_reset = 1'b1;
    strobes = 0;
    for (int c = 0; c < 64; c++) begin
      step();
      if (out_valid) strobes++;
    end
    vectors++;
    if (strobes !== 0) begin
      miscompares++;
      $display("FAIL collision_no_strobe_after: got %0d, want 0", strobes);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    mod_acc     = '0;
    n_reset     = 1'b0;
    in_bit      = 1'b0;
    in_valid    = 1'b0;

    test_reset();
    test_pattern(0, 16'h0000, 16'h0000, "zeros");
    test_pattern(0, 16'h0001, 16'hFFFF, "ones");
    test_pattern(1, 16'h0000, 16'h8000, "alternating");
    test_pattern(2, 16'h4000, 16'h4000, "loopback_4000");
    test_pattern(2, 16'hC000, 16'hC000, "loopback_C000");
    test_gated();
    test_midreset();
    test_reset_tick_collision();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
